// File: rtl/nios_cpu_mult_pkg.sv
// Shared types and helpers for the pipelined Nios II multiplier.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package nios_cpu_mult_pkg;

  // Operation selector carried on in_mode
  typedef enum logic [1:0] {
    MULT_MUL = 2'b00,  // low word of the product, sign independent
    MULT_XSS = 2'b01,  // high word, A signed,   B signed
    MULT_XSU = 2'b10,  // high word, A signed,   B unsigned
    MULT_XUU = 2'b11   // high word, A unsigned, B unsigned
  } mult_mode_t;

  // Number of PIECE_W slices that make up one DATA_W operand
  function automatic int num_pieces(input int data_w, input int piece_w);
    return data_w / piece_w;
  endfunction

  // Returns {src1_signed, src2_signed} for a mode
  function automatic logic [1:0] mode_signedness(input mult_mode_t mode);
    case (mode)
      MULT_XSS: return 2'b11;
      MULT_XSU: return 2'b10;
      default:  return 2'b00;
    endcase
  endfunction

endpackage

// File: rtl/nios_cpu_mult_pp_array.sv
// Slice-pair partial-product multipliers with their output registers (S2).
// Latency: 1 cycle from a_ext/b_ext to pp.
// Backpressure: registers load only while en is high, otherwise hold.
module nios_cpu_mult_pp_array #(
  parameter int DATA_W  = 32,
  parameter int PIECE_W = 16,
  parameter int NP      = DATA_W / PIECE_W,
  parameter int PP_W    = 2 * PIECE_W + 2,
  parameter logic [NP*NP-1:0] PAIR_MASK = '1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        en,
  input  logic [DATA_W:0]             a_ext,
  input  logic [DATA_W:0]             b_ext,
  output logic [NP*NP-1:0][PP_W-1:0]  pp
);

  // Every slice is carried as a signed PIECE_W+1 value: the low slices get a
  // zero on top, the top slice owns the remaining bits including the sign.
  localparam int SL_W = PIECE_W + 1;

  logic [NP-1:0][SL_W-1:0] a_sl;
  logic [NP-1:0][SL_W-1:0] b_sl;

  // Cut the extended operands into slices
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < NP; i++) begin
      if (i == NP - 1) begin
        a_sl[i] = a_ext[DATA_W -: SL_W];
        b_sl[i] = b_ext[DATA_W -: SL_W];
      end else begin
        a_sl[i] = {1'b0, a_ext[i*PIECE_W +: PIECE_W]};
        b_sl[i] = {1'b0, b_ext[i*PIECE_W +: PIECE_W]};
      end
    end
  end

  for (genvar i = 0; i < NP; i++) begin : g_a
    for (genvar j = 0; j < NP; j++) begin : g_b
      localparam int K = i * NP + j;
      if (PAIR_MASK[K]) begin : g_mul
        logic signed [PP_W-1:0] a_x;
        logic signed [PP_W-1:0] b_x;
        logic signed [PP_W-1:0] prod;
        logic        [PP_W-1:0] pp_q;

        assign a_x  = PP_W'($signed(a_sl[i]));
        assign b_x  = PP_W'($signed(b_sl[j]));
        assign prod = a_x * b_x;

        // Register the slice product while the pipe advances
        always_ff @(posedge clk or posedge reset) begin
          if (reset) begin
            pp_q <= '0;
          end else if (en) begin
            pp_q <= prod;
          end
        end

        assign pp[K] = pp_q;
      end else begin : g_none
        assign pp[K] = '0;
      end
    end
  end

endmodule

// File: rtl/nios_cpu_nios2_cpu_mult_pipe.sv
// Three-stage pipelined multiplier (S1 extend, S2 partial products, S3 sum); high-word modes with NIOS_MULT_PIPE_HI_EN.
// Latency: result valid in the third cycle after the offering cycle; one operation per cycle.
// Backpressure: out_valid & ~out_ready freezes every stage and drops in_ready.
module nios_cpu_nios2_cpu_mult_pipe
  import nios_cpu_mult_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int PIECE_W = 16,
  parameter int TAG_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_src1,
  input  logic [DATA_W-1:0] in_src2,
  input  logic [1:0]        in_mode,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_result,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int NUM_PIECES = num_pieces(DATA_W, PIECE_W);
  localparam int PP_W       = 2 * PIECE_W + 2;
`ifdef NIOS_MULT_PIPE_HI_EN
  localparam int SUM_W      = 2 * DATA_W;
`else
  localparam int SUM_W      = DATA_W;
`endif

  // Low-word-only builds keep just the pairs that land below bit DATA_W
  function automatic logic [NUM_PIECES*NUM_PIECES-1:0] pair_mask();
    logic [NUM_PIECES*NUM_PIECES-1:0] m;
    m = '0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      for (int j = 0; j < NUM_PIECES; j++) begin
`ifdef NIOS_MULT_PIPE_HI_EN
        m[i*NUM_PIECES+j] = 1'b1;
`else
        m[i*NUM_PIECES+j] = ((i + j) < NUM_PIECES);
`endif
      end
    end
    return m;
  endfunction

  localparam logic [NUM_PIECES*NUM_PIECES-1:0] PAIR_MASK = pair_mask();

  logic                   adv;
  logic                   v1, v2, v3;
  mult_mode_t             mode_in;
  logic [1:0]             sgn;
  logic [DATA_W:0]        a1, b1;
  logic [TAG_W-1:0]       tag1, tag2;
  logic [NUM_PIECES*NUM_PIECES-1:0][PP_W-1:0] pp;
  logic [SUM_W-1:0]       sum;
  logic [DATA_W-1:0]      res_d;
`ifdef NIOS_MULT_PIPE_HI_EN
  logic                   hi1, hi2;
`else
  logic                   unused_mode;
  assign unused_mode = ^in_mode;
`endif

  // The only stall source is a held result at the output
  assign adv       = ~(v3 & ~out_ready);
  assign in_ready  = adv;
  assign out_valid = v3;

  // Decode mode into operand signedness
  always_comb begin
`ifdef NIOS_MULT_PIPE_HI_EN
    mode_in = mult_mode_t'(in_mode);
`else
    mode_in = MULT_MUL;
`endif
    sgn = mode_signedness(mode_in);
  end

  // S1: capture extended operands and tag of an accepted operation
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v1   <= 1'b0;
      a1   <= '0;
      b1   <= '0;
      tag1 <= '0;
    end else if (adv) begin
      v1 <= in_valid;
      if (in_valid) begin
        a1   <= {sgn[1] & in_src1[DATA_W-1], in_src1};
        b1   <= {sgn[0] & in_src2[DATA_W-1], in_src2};
        tag1 <= in_tag;
      end
    end
  end

`ifdef NIOS_MULT_PIPE_HI_EN
  // High-word select travels with the operation through S1 and S2
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi1 <= 1'b0;
      hi2 <= 1'b0;
    end else if (adv) begin
      if (in_valid) hi1 <= (mode_in != MULT_MUL);
      if (v1)       hi2 <= hi1;
    end
  end
`endif

  // S2: slice-pair products, loaded only when S1 holds a live operation
  nios_cpu_mult_pp_array #(
    .DATA_W    (DATA_W),
    .PIECE_W   (PIECE_W),
    .NP        (NUM_PIECES),
    .PP_W      (PP_W),
    .PAIR_MASK (PAIR_MASK)
  ) u_pp (
    .clk   (clk),
    .reset (reset),
    .en    (adv & v1),
    .a_ext (a1),
    .b_ext (b1),
    .pp    (pp)
  );

  // S2 control: valid and tag alongside the partial products
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v2   <= 1'b0;
      tag2 <= '0;
    end else if (adv) begin
      v2 <= v1;
      if (v1) tag2 <= tag1;
    end
  end

  // S3 input: shift-align and add the sign-extended partial products
  always_comb begin
    sum = '0;
    for (int i = 0; i < NUM_PIECES; i++) begin
      for (int j = 0; j < NUM_PIECES; j++) begin
        if (PAIR_MASK[i*NUM_PIECES+j]) begin
          sum = sum + (SUM_W'($signed(pp[i*NUM_PIECES+j])) << ((i + j) * PIECE_W));
        end
      end
    end
  end

  // Pick the requested product word
  always_comb begin
`ifdef NIOS_MULT_PIPE_HI_EN
    res_d = hi2 ? sum[2*DATA_W-1:DATA_W] : sum[DATA_W-1:0];
`else
    res_d = sum;
`endif
  end

  // S3: output register, changes only when a live result arrives
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      v3         <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
    end else if (adv) begin
      v3 <= v2;
      if (v2) begin
        out_result <= res_d;
        out_tag    <= tag2;
      end
    end
  end

endmodule
